// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register map, CTRL field layout
// and the decoded CTRL flag bundle.
package timer_bank_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_PSEL_LSB     = 8;

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic enable;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [31:0] d);
    ctrl_t c;
    c.irq_en   = d[CTRL_IRQ_EN_BIT];
    c.periodic = d[CTRL_PERIODIC_BIT];
    c.enable   = d[CTRL_ENABLE_BIT];
    return c;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: CTRL/RELOAD/STATUS registers, power-of-two prescaler,
// down-counter with one-shot/periodic expiry and a sticky pending flag.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int COUNTER_WIDTH     = 32,
  parameter int PRESCALE_SEL_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_ctrl,
  input  logic        wr_reload,
  input  logic        wr_status,
  input  logic [31:0] data_in,
  output logic [31:0] ctrl_rd,
  output logic [31:0] reload_rd,
  output logic [31:0] count_rd,
  output logic [31:0] status_rd,
  output logic        interrupt
);

  localparam int CW = COUNTER_WIDTH;
  localparam int PSB = PRESCALE_SEL_BITS;
  localparam int PW = 2**PSB - 1;

  ctrl_t          ctrl;
  ctrl_t          wr_fields;
  logic [PSB-1:0] psel;
  logic [PSB-1:0] psel_wr;
  logic [CW-1:0]  reload;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_n;
  logic [PW-1:0]  presc;
  logic [PW-1:0]  presc_n;
  logic [PW-1:0]  presc_max;
  logic [PW:0]    presc_span;
  logic           pending;
  logic           tick;
  logic           expire;
  logic           enable_n;
  logic           psel_change;
  logic           unused_data;

  assign wr_fields   = decode_ctrl(data_in);
  assign psel_wr     = data_in[CTRL_PSEL_LSB +: PSB];
  assign psel_change = psel_wr != psel;
  assign unused_data = ^data_in;

  // Top select value wraps to zero in PW bits, so max becomes all ones.
  assign presc_span = (PW+1)'(1) << psel;
  assign presc_max  = presc_span[PW-1:0] - PW'(1);
  assign tick       = presc == presc_max;
  assign expire     = ctrl.enable && (count == '0 || (tick && count == CW'(1)));

  always_comb begin
    count_n  = count;
    presc_n  = presc;
    enable_n = ctrl.enable;
    if (expire) begin
      presc_n = '0;
      if (ctrl.periodic && reload != '0) begin
        count_n = reload;
      end else begin
        count_n  = '0;
        enable_n = 1'b0;
      end
    end else if (ctrl.enable) begin
      if (tick) begin
        count_n = count - CW'(1);
        presc_n = '0;
      end else begin
        presc_n = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      psel    <= '0;
      reload  <= '0;
      count   <= '0;
      presc   <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_reload) begin
        reload      <= data_in[CW-1:0];
        count       <= data_in[CW-1:0];
        presc       <= '0;
        ctrl.enable <= 1'b1;
      end else if (wr_ctrl) begin
        ctrl <= wr_fields;
        psel <= psel_wr;
        if (wr_fields.enable) begin
          count <= count_n;
          presc <= psel_change ? '0 : presc_n;
        end
      end else begin
        ctrl.enable <= enable_n;
        count       <= count_n;
        presc       <= presc_n;
      end
      // Register writes that restart or stop the channel override expiry;
      // a STATUS clear does not.
      if (expire && !wr_reload && !(wr_ctrl && !wr_fields.enable)) begin
        pending <= 1'b1;
      end else if (wr_status && data_in[0]) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_ENABLE_BIT]           = ctrl.enable;
    ctrl_rd[CTRL_PERIODIC_BIT]         = ctrl.periodic;
    ctrl_rd[CTRL_IRQ_EN_BIT]           = ctrl.irq_en;
    ctrl_rd[CTRL_PSEL_LSB +: PSB]      = psel;
  end

  assign reload_rd = 32'(reload);
  assign count_rd  = 32'(count);
  assign status_rd = {31'b0, pending};
  assign interrupt = pending & ctrl.irq_en;

endmodule

// File: rtl/timer_bank.sv
// Bank of independent countdown timers behind a word-addressed register port;
// address is {channel, reg}, reads are combinational.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int COUNTER_WIDTH     = 32,
  parameter int PRESCALE_SEL_BITS = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              write,
  input  logic [$clog2(NUM_CHANNELS)+1:0]   address,
  input  logic [31:0]                       data_in,
  output logic [31:0]                       data_out,
  output logic [NUM_CHANNELS-1:0]           timer_interrupt,
  output logic                              irq_any
);

  localparam int AW = $clog2(NUM_CHANNELS) + 2;

  logic [AW-1:0] ch_sel;
  logic [1:0]    reg_sel;
  logic [31:0]   ctrl_rd   [NUM_CHANNELS];
  logic [31:0]   reload_rd [NUM_CHANNELS];
  logic [31:0]   count_rd  [NUM_CHANNELS];
  logic [31:0]   status_rd [NUM_CHANNELS];

  assign ch_sel  = address >> 2;
  assign reg_sel = address[1:0];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic sel;
    assign sel = write && (ch_sel == AW'(g));

    timer_channel #(
      .COUNTER_WIDTH    (COUNTER_WIDTH),
      .PRESCALE_SEL_BITS(PRESCALE_SEL_BITS)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .wr_ctrl  (sel && reg_sel == REG_CTRL),
      .wr_reload(sel && reg_sel == REG_RELOAD),
      .wr_status(sel && reg_sel == REG_STATUS),
      .data_in  (data_in),
      .ctrl_rd  (ctrl_rd[g]),
      .reload_rd(reload_rd[g]),
      .count_rd (count_rd[g]),
      .status_rd(status_rd[g]),
      .interrupt(timer_interrupt[g])
    );
  end

  // Addresses beyond the last channel read as zero.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_CTRL:   data_out = ctrl_rd[i];
          REG_RELOAD: data_out = reload_rd[i];
          REG_COUNT:  data_out = count_rd[i];
          REG_STATUS: data_out = status_rd[i];
        endcase
      end
    end
  end

  assign irq_any = |timer_interrupt;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: latency, prescaling, periodic reload,
// same-edge write/expiry priority, irq masking and asynchronous reset.
module tb_timer_bank;

  localparam int R_CTRL = 0, R_RELOAD = 1, R_COUNT = 2, R_STATUS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [3:0]  timer_interrupt;
  logic        irq_any;

  timer_bank #(
    .NUM_CHANNELS(4), .COUNTER_WIDTH(32), .PRESCALE_SEL_BITS(3)
  ) dut (
    .clk(clk), .rst(rst), .write(write), .address(address), .data_in(data_in),
    .data_out(data_out), .timer_interrupt(timer_interrupt), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rise [4] = '{default: 0};
  int rise_cnt  [4] = '{default: 0};
  logic [3:0] prev_irq = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the cycle of every rising edge of each interrupt line.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 4; c++) begin
      if (timer_interrupt[c] && !prev_irq[c]) begin
        last_rise[c] = cyc;
        rise_cnt[c]  = rise_cnt[c] + 1;
      end
    end
    prev_irq = timer_interrupt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    @(negedge clk);
    write   = 1'b1;
    address = 4'(ch * 4 + r);
    data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] v);
    address = 4'(ch * 4 + r);
    #1;
    v = data_out;
  endtask

  task automatic wait_rise(input int c, input int base, input int limit);
    int n = 0;
    while (rise_cnt[c] == base && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk($sformatf("rise_timeout_ch%0d", c), 32'(rise_cnt[c] == base), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int w;
    int base;
    int wcyc [4];
    int bases [4];
    int nval  [2][4] = '{'{37, 150, 9, 41}, '{0, 1, 25, 3}};
    int exp_d [2][4] = '{'{37, 300, 36, 328}, '{1, 2, 100, 24}};

    // Reset state
    #2;
    chk("rst_irq", 32'(timer_interrupt), 32'd0);
    chk("rst_irq_any", 32'(irq_any), 32'd0);
    for (int r = 0; r < 4; r++) begin
      rd(0, r, v);
      chk($sformatf("rst_ch0_reg%0d", r), v, 32'd0);
    end
    rd(3, R_CTRL, v);
    chk("rst_ch3_ctrl", v, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Channel 0: p=0, irq_en, RELOAD=100 -> interrupt 100 cycles after write edge
    wr(0, R_CTRL, 32'h4);
    base = rise_cnt[0];
    wr(0, R_RELOAD, 32'd100);
    w = cyc;
    wait_rise(0, base, 200);
    chk("t1_latency", 32'(last_rise[0] - w), 32'd100);
    rd(0, R_COUNT, v);
    chk("t1_count", v, 32'd0);
    rd(0, R_CTRL, v);
    chk("t1_ctrl", v, 32'h4);
    rd(0, R_STATUS, v);
    chk("t1_status", v, 32'd1);
    chk("t1_irq_vec", 32'(timer_interrupt), 32'h1);
    chk("t1_irq_any", 32'(irq_any), 32'd1);
    wr(0, R_STATUS, 32'd1);
    chk("t1_clear", 32'(timer_interrupt), 32'h0);
    wr(0, R_COUNT, 32'd123);
    rd(0, R_COUNT, v);
    chk("count_ro", v, 32'd0);
    wr(0, R_CTRL, 32'hFFFF_FFFE);
    rd(0, R_CTRL, v);
    chk("ctrl_unused_bits", v, 32'h706);

    // Four channels concurrently, p = channel index
    for (int c = 0; c < 4; c++) wr(c, R_CTRL, 32'h4 | (c << 8));
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        bases[c] = rise_cnt[c];
        wr(c, R_RELOAD, nval[r][c]);
        wcyc[c] = cyc;
      end
      for (int c = 0; c < 4; c++) wait_rise(c, bases[c], 500);
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("conc_r%0d_ch%0d_delay", r, c), 32'(last_rise[c] - wcyc[c]), 32'(exp_d[r][c]));
        rd(c, R_COUNT, v);
        chk($sformatf("conc_r%0d_ch%0d_count", r, c), v, 32'd0);
        rd(c, R_CTRL, v);
        chk($sformatf("conc_r%0d_ch%0d_ctrl", r, c), v, 32'h4 | (c << 8));
        rd(c, R_RELOAD, v);
        chk($sformatf("conc_r%0d_ch%0d_reload", r, c), v, 32'(nval[r][c]));
      end
      for (int c = 0; c < 4; c++) wr(c, R_STATUS, 32'd1);
    end

    // Periodic on channel 1: p=2, RELOAD=5 -> every 20 cycles
    wr(1, R_CTRL, 32'h206);
    wr(1, R_RELOAD, 32'd5);
    w = cyc;
    for (int k = 1; k <= 3; k++) begin
      base = rise_cnt[1];
      wait_rise(1, base, 100);
      chk($sformatf("per_edge%0d", k), 32'(last_rise[1] - w), 32'(20 * k));
      rd(1, R_COUNT, v);
      chk($sformatf("per_reload%0d", k), v, 32'd5);
      wr(1, R_STATUS, 32'd1);
      chk($sformatf("per_clear%0d", k), 32'(timer_interrupt[1]), 32'd0);
    end
    wr(1, R_CTRL, 32'h0);
    wr(1, R_STATUS, 32'd1);

    // STATUS clear landing on the expiry edge: pending survives
    wr(2, R_CTRL, 32'h4);
    wr(2, R_RELOAD, 32'd10);
    repeat (9) @(posedge clk);
    wr(2, R_STATUS, 32'd1);
    rd(2, R_STATUS, v);
    chk("clr_vs_expiry_pending", v, 32'd1);
    chk("clr_vs_expiry_irq", 32'(timer_interrupt[2]), 32'd1);
    wr(2, R_STATUS, 32'd1);

    // CTRL enable=0 landing on the expiry edge: no pending, count frozen at 1
    wr(2, R_RELOAD, 32'd10);
    repeat (9) @(posedge clk);
    wr(2, R_CTRL, 32'h4);
    rd(2, R_STATUS, v);
    chk("dis_vs_expiry_pending", v, 32'd0);
    rd(2, R_COUNT, v);
    chk("dis_vs_expiry_count", v, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    rd(2, R_COUNT, v);
    chk("dis_frozen_count", v, 32'd1);
    chk("dis_no_irq", 32'(timer_interrupt[2]), 32'd0);

    // irq_en masks the line only; RELOAD=0 expires on the next edge
    wr(3, R_CTRL, 32'h0);
    wr(3, R_RELOAD, 32'd4);
    repeat (6) @(posedge clk);
    #1;
    rd(3, R_STATUS, v);
    chk("mask_pending", v, 32'd1);
    chk("mask_irq", 32'(timer_interrupt[3]), 32'd0);
    chk("mask_irq_any", 32'(irq_any), 32'd0);
    wr(3, R_CTRL, 32'h4);
    chk("unmask_irq", 32'(timer_interrupt[3]), 32'd1);
    chk("unmask_irq_any", 32'(irq_any), 32'd1);
    wr(3, R_STATUS, 32'd1);
    chk("unmask_clear", 32'(timer_interrupt[3]), 32'd0);
    wr(3, R_RELOAD, 32'd0);
    rd(3, R_STATUS, v);
    chk("zero_reload_at_write", v, 32'd0);
    @(posedge clk);
    #1;
    rd(3, R_STATUS, v);
    chk("zero_reload_next_edge", v, 32'd1);
    chk("zero_reload_irq", 32'(timer_interrupt), 32'h8);

    // Asynchronous reset mid-count
    wr(0, R_CTRL, 32'h4);
    wr(0, R_RELOAD, 32'd1000);
    repeat (300) @(posedge clk);
    #1;
    rd(0, R_COUNT, v);
    chk("pre_rst_count", v, 32'd700);
    chk("pre_rst_irq", 32'(timer_interrupt), 32'h8);
    rst = 1'b1;
    #1;
    chk("async_rst_irq", 32'(timer_interrupt), 32'h0);
    chk("async_rst_irq_any", 32'(irq_any), 32'd0);
    chk("async_rst_count", data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = rise_cnt[0];
    repeat (1100) @(posedge clk);
    #1;
    chk("post_rst_no_rise", 32'(rise_cnt[0]), 32'(base));
    chk("post_rst_irq", 32'(timer_interrupt), 32'h0);
    wr(0, R_CTRL, 32'h4);
    wr(0, R_RELOAD, 32'd3);
    w = cyc;
    wait_rise(0, base, 20);
    chk("post_rst_restart", 32'(last_rise[0] - w), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel programmable countdown timer, the parametrised successor of the single-channel `Timer`. Provides NUM_CHANNELS independent down-counters, each with its own power-of-two prescaler, one-shot or periodic mode, sticky pending flag and per-channel interrupt enable. Sits on the CPU peripheral bus behind a word-addressed register interface and drives per-channel and combined interrupt lines to the interrupt controller.

## Interface
- `NUM_CHANNELS`, 4: number of timer channels, ≥1.
- `COUNTER_WIDTH`, 32: counter and reload width, ≤32.
- `PRESCALE_SEL_BITS`, 3: width of the prescale select field. Tick divisor is 2^p, with p in 0..2^PRESCALE_SEL_BITS−1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `write`  in  1  register write strobe, one write per cycle.
- `address`  in  $clog2(NUM_CHANNELS)+2  {channel, reg}. Reg: 0 CTRL, 1 RELOAD, 2 COUNT, 3 STATUS.
- `data_in`  in  32  write data.
- `data_out`  out  32  combinational read of the addressed register.
- `timer_interrupt`  out  NUM_CHANNELS  per channel: pending & irq_en.
- `irq_any`  out  1  OR of `timer_interrupt`.

## Operation
- Register bits. Unused bits read 0 and ignore writes.
  - CTRL: bit0 enable, bit1 periodic, bit2 irq_en, bits[8 +: PRESCALE_SEL_BITS] prescale select p.
  - RELOAD: `COUNTER_WIDTH` bits, read/write.
  - COUNT: live counter, read-only. Writes are ignored.
  - STATUS: bit0 pending. Writing 1 clears it; writing 0 has no effect.
- Writing RELOAD with N stores N, loads count ← N, clears the channel prescaler and sets enable. Mode, irq_en and p are unchanged.
- Writing CTRL updates all fields. Setting enable does not reload the count.
  - A write that changes p clears the prescaler.
  - Enable=0 freezes count and prescaler.
- Channel states: IDLE (enable=0) and RUN (enable=1).
- Behaviour in RUN:
  - The prescaler increments every cycle. When it equals 2^p−1 it wraps to 0 and issues a tick; with p=0 every cycle is a tick.
  - Each tick decrements count.
- Expiry: a tick with count==1, or RUN with count==0. At expiry:
  - pending ← 1 and count ← 0.
  - Periodic with RELOAD≠0: count ← RELOAD, prescaler ← 0, stay in RUN.
  - Otherwise (one-shot, or periodic with RELOAD==0): enable ← 0, go to IDLE.
- Pending is sticky regardless of irq_en. irq_en masks only `timer_interrupt`.
- Channels are fully independent. A write to one channel never affects another.

## Timing
- Reset values: all registers, counts, prescalers and pending flags are 0.
  - `timer_interrupt`=0, `irq_any`=0.
  - `data_out` reflects the zeroed registers.
- Latency from the RELOAD write edge (N≥1, divisor 2^p):
  - pending rises at the edge N·2^p cycles later.
  - `timer_interrupt` is visible immediately after that edge.
  - N=0: pending rises at the next edge.
- Periodic mode: subsequent expiries are exactly RELOAD·2^p cycles apart. No cycle is lost at reload.
- Simultaneous events on the same edge:
  - STATUS clear with expiry: expiry wins, pending stays 1.
  - CTRL write of enable=0 with expiry: the write wins. No pending, count is frozen.
  - RELOAD write with expiry: the write wins. Restart with N, no pending.
- Wrap-around: count never underflows. It reaches 0 only through expiry.
- Asynchronous reset mid-run aborts everything immediately. Outputs go to 0 without waiting for a clock edge.

## Structure
- Package `timer_bank_pkg` holds:
  - register offsets (CTRL, RELOAD, COUNT, STATUS);
  - CTRL bit positions;
  - a `ctrl_t` packed struct.
- Sub-module `timer_channel` holds one channel: registers, prescaler, counter, expiry/mode logic and pending.
  - Ports: `clk`, `rst`, per-register write enables, `data_in`, register readbacks, interrupt.
- The top level holds the address decode, the read mux and the generate loop over channels.

## Test plan
- Reset, then channel 0: CTRL p=0, irq_en=1. Write RELOAD=100 → `timer_interrupt[0]` rises exactly 100 cycles after the write edge. COUNT reads 0 and enable reads 0.
- Channel c=0..3 with p=c, RELOAD=random 0..2000 (20 runs each, channels concurrent) → expiry at RELOAD·2^c cycles. The other channels are undisturbed.
- Periodic, p=2, RELOAD=5 → pending edges every 20 cycles. Clear pending between events → re-asserts at each period.
- STATUS clear on the expiry edge → pending stays 1. CTRL enable=0 on the expiry edge → no pending, COUNT frozen at 1.
- irq_en=0, expiry → STATUS.pending=1, `timer_interrupt`=0. Set irq_en → interrupt asserts next cycle. Write RELOAD=0 → pending at the next edge.
- Assert `rst` mid-count (RELOAD=1000, 300 cycles in) → all outputs 0 immediately. No interrupt after release until a new RELOAD write.
